exe_stage: RTL and testbench

Execute stage of the 5-stage ARM-subset pipeline, placed directly downstream of the ID/EXE pipeline register and feeding the memory stage. It forms the second operand (Val2) from immediate, shifted-register or memory-offset encodings, runs the ALU and updates the NZCV status register when `S` is set. It computes the branch target and registers all results into its EXE/MEM output register. That output register holds its contents during a memory-stage freeze.

---
 rtl/arm_pkg.sv | 37 +++
 rtl/val2_generator.sv | 51 +++++
 rtl/exe_stage.sv | 139 +++++++++++++
 tb/tb_exe_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ALU command, shift-type and NZCV constants for the ARM-subset pipeline
//
// Contents:
//   EXE_* : ALU operation codes carried on EXE_CMD.
//   SHIFT_*: register shift types taken from instruction bits [6:5].
//   FLAG_*: bit positions inside the 4-bit NZCV status word.
//   ror32 : 32-bit rotate right, shared by the immediate and register paths.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Doubling the word lets a plain right shift act as a rotate.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/val2_generator.sv
// rtl/val2_generator.sv - combinational second-operand former for the execute stage
//
// Ports:
//   Val_Rm        in  32 : register operand Rm
//   Shift_operand in  12 : instruction bits [11:0]
//   imm           in   1 : I bit
//   mem_access    in   1 : load/store, selects the 12-bit unsigned offset
//   Val2          out 32 : second ALU operand
module val2_generator
    import arm_pkg::*;
(
    input  logic [31:0] Val_Rm,
    input  logic [11:0] Shift_operand,
    input  logic        imm,
    input  logic        mem_access,
    output logic [31:0] Val2
);

    logic [4:0]  shift_amt;
    logic [31:0] rot_imm;
    logic [31:0] shifted;

    assign shift_amt = Shift_operand[11:7];

    // 8-bit immediate rotated right by twice the 4-bit rotate field.
    assign rot_imm = ror32({24'd0, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0});

    // A zero amount leaves Rm untouched for every type, so no special case is needed.
    always_comb begin
        shifted = Val_Rm;
        case (Shift_operand[6:5])
            SHIFT_LSL: shifted = Val_Rm << shift_amt;
            SHIFT_LSR: shifted = Val_Rm >> shift_amt;
            SHIFT_ASR: shifted = $unsigned($signed(Val_Rm) >>> shift_amt);
            SHIFT_ROR: shifted = ror32(Val_Rm, shift_amt);
            default:   shifted = Val_Rm;
        endcase
    end

    // Memory offset wins over the I bit.
    always_comb begin
        if (mem_access) begin
            Val2 = {20'd0, Shift_operand};
        end else if (imm) begin
            Val2 = rot_imm;
        end else begin
            Val2 = shifted;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: Val2, ALU, NZCV status register, branch target, EXE/MEM register
//
// Ports:
//   clk, rst (sync, active-high), freeze (hold all state)
//   *_IN          : ID/EXE register contents (controls, PC+4, operands, shift field, imm24, dest)
//   WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, Dest : registered EXE/MEM outputs
//   Branch_Taken, Branch_Addr : combinational branch decision and target
//   Status        : registered NZCV (bit 3 = N), fed back to the condition check
module exe_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic        B_IN,
    input  logic        S_IN,
    input  logic [3:0]  EXE_CMD_IN,
    input  logic [31:0] PC_IN,
    input  logic [31:0] Val_Rn_IN,
    input  logic [31:0] Val_Rm_IN,
    input  logic        imm_IN,
    input  logic [11:0] Shift_operand_IN,
    input  logic [23:0] Signed_imm_24_IN,
    input  logic [3:0]  Dest_IN,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic [31:0] ALU_Res,
    output logic [31:0] Val_Rm,
    output logic [3:0]  Dest,
    output logic        Branch_Taken,
    output logic [31:0] Branch_Addr,
    output logic [3:0]  Status
);

    logic [31:0] val2;
    logic [31:0] alu_res;
    logic [31:0] op_b;
    logic        cin_eff;
    logic [32:0] sum33;
    logic        arith;
    logic        logical;
    logic [3:0]  flags_new;
    logic        c_in;

    logic        wb_en_q, mem_r_en_q, mem_w_en_q;
    logic [31:0] alu_res_q, val_rm_q;
    logic [3:0]  dest_q;
    logic [3:0]  status_q, status_d;

    val2_generator u_val2 (
        .Val_Rm        (Val_Rm_IN),
        .Shift_operand (Shift_operand_IN),
        .imm           (imm_IN),
        .mem_access    (MEM_R_EN_IN | MEM_W_EN_IN),
        .Val2          (val2)
    );

    assign c_in = status_q[FLAG_C];

    // Subtraction is Rn + ~Val2 + carry-in, so one adder and one overflow rule serve all four
    // arithmetic ops; C out of bit 32 is then "no borrow" for SUB/SBC.
    always_comb begin
        op_b    = val2;
        cin_eff = 1'b0;
        arith   = 1'b0;
        logical = 1'b0;
        alu_res = 32'd0;
        case (EXE_CMD_IN)
            EXE_ADD: begin arith = 1'b1; end
            EXE_ADC: begin arith = 1'b1; cin_eff = c_in; end
            EXE_SUB: begin arith = 1'b1; op_b = ~val2; cin_eff = 1'b1; end
            EXE_SBC: begin arith = 1'b1; op_b = ~val2; cin_eff = c_in; end
            default: begin end
        endcase

        sum33 = {1'b0, Val_Rn_IN} + {1'b0, op_b} + {32'd0, cin_eff};

        case (EXE_CMD_IN)
            EXE_MOV: begin alu_res = val2;              logical = 1'b1; end
            EXE_MVN: begin alu_res = ~val2;             logical = 1'b1; end
            EXE_AND: begin alu_res = Val_Rn_IN & val2;  logical = 1'b1; end
            EXE_ORR: begin alu_res = Val_Rn_IN | val2;  logical = 1'b1; end
            EXE_EOR: begin alu_res = Val_Rn_IN ^ val2;  logical = 1'b1; end
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: alu_res = sum33[31:0];
            default: alu_res = 32'd0;
        endcase
    end

    // Unknown commands leave all four flags as they were; logical ops keep C and V.
    always_comb begin
        flags_new = status_q;
        if (arith || logical) begin
            flags_new[FLAG_N] = alu_res[31];
            flags_new[FLAG_Z] = (alu_res == 32'd0);
        end
        if (arith) begin
            flags_new[FLAG_C] = sum33[32];
            flags_new[FLAG_V] = (Val_Rn_IN[31] == op_b[31]) && (alu_res[31] != Val_Rn_IN[31]);
        end
    end

    assign status_d = S_IN ? flags_new : status_q;

    assign Branch_Taken = B_IN;
    assign Branch_Addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= 32'd0;
            val_rm_q   <= 32'd0;
            dest_q     <= 4'd0;
            status_q   <= 4'd0;
        end else if (!freeze) begin
            wb_en_q    <= WB_EN_IN;
            mem_r_en_q <= MEM_R_EN_IN;
            mem_w_en_q <= MEM_W_EN_IN;
            alu_res_q  <= alu_res;
            val_rm_q   <= Val_Rm_IN;
            dest_q     <= Dest_IN;
            status_q   <= status_d;
        end
    end

    assign WB_EN    = wb_en_q;
    assign MEM_R_EN = mem_r_en_q;
    assign MEM_W_EN = mem_w_en_q;
    assign ALU_Res  = alu_res_q;
    assign Val_Rm   = val_rm_q;
    assign Dest     = dest_q;
    assign Status   = status_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage with directed and random stimulus
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
    logic        imm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, Branch_Taken;
    logic [31:0] ALU_Res, Val_Rm, Branch_Addr;
    logic [3:0]  Dest, Status;

    int n_checks = 0;
    int n_fail   = 0;

    logic        e_wb, e_mr, e_mw;
    logic [31:0] e_res, e_rm;
    logic [3:0]  e_dest, e_status;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
        .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
        .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
        .Dest_IN(Dest_IN), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .Branch_Taken(Branch_Taken),
        .Branch_Addr(Branch_Addr), .Status(Status)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Shifts done one bit position at a time.
    function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] so,
                                           input logic im, input logic mem);
        logic [31:0] v;
        int amt;
        if (mem) return {20'd0, so};
        if (im) begin
            v = {24'd0, so[7:0]};
            amt = 2 * int'(so[11:8]);
            for (int i = 0; i < amt; i++) v = {v[0], v[31:1]};
            return v;
        end
        v = rm;
        amt = int'(so[11:7]);
        for (int i = 0; i < amt; i++) begin
            case (so[6:5])
                2'b00:   v = {v[30:0], 1'b0};
                2'b01:   v = {1'b0, v[31:1]};
                2'b10:   v = {v[31], v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    // Integer-arithmetic ALU model; returns result and the post-op NZCV.
    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] b,
                         input logic [3:0] st, output logic [31:0] res, output logic [3:0] nst);
        longint ua, ub, u, sa, sb, s, brw;
        logic c, v, ok, ar;
        ua = longint'({32'd0, rn});
        ub = longint'({32'd0, b});
        sa = $signed(rn);
        sb = $signed(b);
        c = st[1]; v = st[0]; ok = 1'b1; ar = 1'b0; res = 32'd0; s = 0; u = 0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0110: res = rn & b;
            4'b0111: res = rn | b;
            4'b1000: res = rn ^ b;
            4'b0010, 4'b0011: begin
                brw = (cmd == 4'b0011) ? longint'(st[1]) : 0;
                u = ua + ub + brw;
                s = sa + sb + brw;
                c = (u >= 64'sd4294967296);
                ar = 1'b1;
            end
            4'b0100, 4'b0101: begin
                brw = (cmd == 4'b0101) ? longint'(!st[1]) : 0;
                u = ua - ub - brw;
                s = sa - sb - brw;
                c = (ua >= ub + brw);
                ar = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (ar) begin
            res = u[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        nst = ok ? {res[31], res == 32'd0, c, v} : st;
    endtask

    function automatic logic [31:0] m_branch(input logic [31:0] pc, input logic [23:0] off);
        longint o, a;
        o = longint'({40'd0, off});
        if (off[23]) o = o - 64'sd16777216;
        a = longint'({32'd0, pc}) + o * 4;
        return a[31:0];
    endfunction

    // Check combinational branch, clock once, update the model, compare registered outputs.
    task automatic tick();
        logic [31:0] r;
        logic [3:0]  ns;
        #1;
        check_eq("br_taken", {31'd0, Branch_Taken}, {31'd0, B_IN});
        check_eq("br_addr", Branch_Addr, m_branch(PC_IN, Signed_imm_24_IN));
        m_alu(EXE_CMD_IN, Val_Rn_IN,
              m_val2(Val_Rm_IN, Shift_operand_IN, imm_IN, MEM_R_EN_IN | MEM_W_EN_IN), e_status, r, ns);
        @(posedge clk);
        if (rst) begin
            e_wb = 0; e_mr = 0; e_mw = 0; e_res = 0; e_rm = 0; e_dest = 0; e_status = 0;
        end else if (!freeze) begin
            e_wb = WB_EN_IN; e_mr = MEM_R_EN_IN; e_mw = MEM_W_EN_IN;
            e_res = r; e_rm = Val_Rm_IN; e_dest = Dest_IN;
            if (S_IN) e_status = ns;
        end
        #1;
        check_eq("wb_en", {31'd0, WB_EN}, {31'd0, e_wb});
        check_eq("mem_r_en", {31'd0, MEM_R_EN}, {31'd0, e_mr});
        check_eq("mem_w_en", {31'd0, MEM_W_EN}, {31'd0, e_mw});
        check_eq("alu_res", ALU_Res, e_res);
        check_eq("val_rm", Val_Rm, e_rm);
        check_eq("dest", {28'd0, Dest}, {28'd0, e_dest});
        check_eq("status", {28'd0, Status}, {28'd0, e_status});
    endtask

    task automatic set_alu(input logic [3:0] cmd, input logic s, input logic im,
                           input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
        WB_EN_IN = 1; MEM_R_EN_IN = 0; MEM_W_EN_IN = 0; B_IN = 0;
        EXE_CMD_IN = cmd; S_IN = s; imm_IN = im; Shift_operand_IN = so;
        Val_Rn_IN = rn; Val_Rm_IN = rm; Dest_IN = 4'(cmd + 1);
    endtask

    initial begin
        rst = 1; freeze = 0;
        set_alu(4'b0000, 0, 0, 12'd0, 32'd0, 32'd0);
        WB_EN_IN = 0; PC_IN = 0; Signed_imm_24_IN = 0;
        e_status = 0;
        tick(); tick();
        rst = 0;

        // ADD overflow -> 0x80000000, NZCV = 1001
        set_alu(4'b0010, 1, 1, 12'h001, 32'h7FFF_FFFF, 32'd0);
        tick();
        check_eq("add_ovf_res", ALU_Res, 32'h8000_0000);
        check_eq("add_ovf_nzcv", {28'd0, Status}, 32'h9);

        set_alu(4'b0001, 0, 1, 12'h2FF, 32'd0, 32'd0);
        tick();
        check_eq("rot_imm", ALU_Res, 32'hF000_000F);

        set_alu(4'b0001, 0, 0, 12'h240, 32'd0, 32'h8000_0000);
        tick();
        check_eq("asr4", ALU_Res, 32'hF800_0000);
        set_alu(4'b0001, 0, 0, 12'h260, 32'd0, 32'h0000_000F);
        tick();
        check_eq("ror4", ALU_Res, 32'hF000_0000);

        set_alu(4'b0010, 0, 0, 12'h004, 32'h100, 32'h55);
        MEM_R_EN_IN = 1;
        tick();
        check_eq("ldr_addr", ALU_Res, 32'h104);

        set_alu(4'b0100, 1, 1, 12'h005, 32'd5, 32'd0);
        B_IN = 1; PC_IN = 32'h20; Signed_imm_24_IN = 24'hFFFFFE;
        #1;
        check_eq("br_addr_dir", Branch_Addr, 32'h18);
        tick();
        B_IN = 0;
        check_eq("cmp_nzcv", {28'd0, Status}, 32'h6);
        set_alu(4'b0101, 1, 1, 12'h003, 32'd5, 32'd0);
        tick();
        check_eq("sbc_res", ALU_Res, 32'd2);

        // Bubble
        set_alu(4'b0000, 0, 0, 12'd0, 32'd0, 32'd0);
        WB_EN_IN = 0;
        tick();

        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            set_alu(4'(i + 2), 1, 0, 12'($urandom), $urandom, $urandom);
            tick();
        end
        rst = 1;
        tick();
        rst = 0; freeze = 0;

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            WB_EN_IN = 1'($urandom); S_IN = 1'($urandom); B_IN = 1'($urandom);
            MEM_R_EN_IN = ($urandom_range(0, 5) == 0);
            MEM_W_EN_IN = ($urandom_range(0, 5) == 0);
            EXE_CMD_IN = 4'($urandom); imm_IN = 1'($urandom);
            Shift_operand_IN = 12'($urandom); Signed_imm_24_IN = 24'($urandom);
            PC_IN = $urandom; Dest_IN = 4'($urandom);
            Val_Rn_IN = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
            Val_Rm_IN = ($urandom_range(0, 3) == 0) ? Val_Rn_IN : $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
